// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: constants shared by the LoongArch MEM pipeline stage.
//   LOAD_OP_* : bit positions inside the one-hot load_op bus
//   DIV_OP_*  : bit positions inside the one-hot div_op bus
//   RESET_PC  : PC presented toward WB while the pipeline is in reset
package mem_stage_pkg;

    localparam int LOAD_OP_B  = 0;
    localparam int LOAD_OP_H  = 1;
    localparam int LOAD_OP_W  = 2;
    localparam int LOAD_OP_BU = 3;
    localparam int LOAD_OP_HU = 4;

    localparam int DIV_OP_DIV_W  = 0;
    localparam int DIV_OP_MOD_W  = 1;
    localparam int DIV_OP_DIV_WU = 2;
    localparam int DIV_OP_MOD_WU = 3;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

endpackage

// File: rtl/mem_stage_load_extend.sv
// mem_stage_load_extend: load_extend unit of the MEM stage. Purely
// combinational byte/halfword/word select plus sign or zero extension.
//   rword   in  32  read word from the data SRAM (or its buffered copy)
//   load_op in  5   one-hot ld.b / ld.h / ld.w / ld.bu / ld.hu
//   offset  in  2   byte offset, low address bits (alignment not checked)
//   value   out 32  extended load value (0 when no load bit is set)
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [4:0]  load_op,
    input  logic [1:0]  offset,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = rword[7:0];
            2'd1:    byte_sel = rword[15:8];
            2'd2:    byte_sel = rword[23:16];
            default: byte_sel = rword[31:24];
        endcase

        // Halfword select uses only offset[1]; a misaligned offset[0] is ignored.
        half_sel = offset[1] ? rword[31:16] : rword[15:0];

        // load_op is one-hot, so the terms can simply be OR-ed together.
        value = '0;
        if (load_op[LOAD_OP_B])  value |= {{24{byte_sel[7]}}, byte_sel};
        if (load_op[LOAD_OP_BU]) value |= {24'd0, byte_sel};
        if (load_op[LOAD_OP_H])  value |= {{16{half_sel[15]}}, half_sel};
        if (load_op[LOAD_OP_HU]) value |= {16'd0, half_sel};
        if (load_op[LOAD_OP_W])  value |= rword;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and WB.
// Consumes the EX bundle (held stable upstream) over in_valid/in_ready,
// picks up the data-SRAM read word, waits for the divider response on
// divide instructions, and registers the final value toward WB.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        EX -> MEM handshake
//   out_valid/out_ready      MEM -> WB handshake (out_valid registered)
//   PC, ex_result, load_op, div_op, res_from_mem, res_from_div,
//   gr_we, dest              EX bundle fields
//   data_sram_rdata          read word, valid only in the first MEM cycle
//   from_div_resp_valid, to_div_resp_ready, div_quotient, div_remainder
//                            divider response channel
//   result                   combinational final value (bypass)
//   result_out, PC_out, gr_we_out, dest_out   registered WB bundle
module mem_stage #(
    parameter logic [31:0] RESET_PC = mem_stage_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [31:0] PC,
    input  logic [31:0] ex_result,
    input  logic [7:0]  load_op,
    input  logic [3:0]  div_op,
    input  logic        res_from_mem,
    input  logic        res_from_div,
    input  logic        gr_we,
    input  logic [4:0]  dest,
    input  logic [31:0] data_sram_rdata,
    input  logic        from_div_resp_valid,
    output logic        to_div_resp_ready,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder,
    output logic [31:0] result,
    output logic [31:0] result_out,
    output logic [31:0] PC_out,
    output logic        gr_we_out,
    output logic [4:0]  dest_out
);

    import mem_stage_pkg::*;

    logic        out_valid_q,  out_valid_d;
    logic [31:0] result_out_q, result_out_d;
    logic [31:0] pc_out_q,     pc_out_d;
    logic        gr_we_out_q,  gr_we_out_d;
    logic [4:0]  dest_out_q,   dest_out_d;
    logic [31:0] rdata_buf_q,  rdata_buf_d;
    logic        first_q,      first_d;

    logic        ready_go;
    logic        advance;
    logic [31:0] rword;
    logic [31:0] load_val;
    logic [31:0] div_val;
    logic        unused_load_op_rsvd;

    assign unused_load_op_rsvd = ^load_op[7:5];

    assign ready_go          = ~in_valid | ~res_from_div | from_div_resp_valid;
    assign in_ready          = ~rst & (~in_valid | (ready_go & out_ready));
    assign advance           = in_valid & ready_go & out_ready;
    // The response is taken only in the cycle it is forwarded to WB, so
    // no holding register for quotient/remainder exists.
    assign to_div_resp_ready = ~rst & in_valid & res_from_div & out_ready;

    // The SRAM word is only valid in the first MEM cycle; later cycles of a
    // stalled load read the buffered copy.
    assign rword = first_q ? data_sram_rdata : rdata_buf_q;

    mem_stage_load_extend u_load_extend (
        .rword   (rword),
        .load_op (load_op[4:0]),
        .offset  (ex_result[1:0]),
        .value   (load_val)
    );

    assign div_val = ({32{div_op[DIV_OP_DIV_W] | div_op[DIV_OP_DIV_WU]}} & div_quotient)
                   | ({32{div_op[DIV_OP_MOD_W] | div_op[DIV_OP_MOD_WU]}} & div_remainder);

    assign result = res_from_mem ? load_val
                  : res_from_div ? div_val
                  : ex_result;

    always_comb begin
        out_valid_d  = out_valid_q;
        result_out_d = result_out_q;
        pc_out_d     = pc_out_q;
        gr_we_out_d  = gr_we_out_q;
        dest_out_d   = dest_out_q;

        // Whenever the stage is empty or advancing, whatever EX presents
        // next cycle is a fresh instruction with its SRAM word on the bus.
        first_d     = in_ready;
        rdata_buf_d = first_q ? data_sram_rdata : rdata_buf_q;

        if (out_ready) begin
            out_valid_d = in_valid & ready_go;
        end

        if (advance) begin
            result_out_d = result;
            pc_out_d     = PC;
            gr_we_out_d  = gr_we;
            dest_out_d   = dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            result_out_q <= '0;
            pc_out_q     <= RESET_PC;
            gr_we_out_q  <= 1'b0;
            dest_out_q   <= '0;
            rdata_buf_q  <= '0;
            first_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            result_out_q <= result_out_d;
            pc_out_q     <= pc_out_d;
            gr_we_out_q  <= gr_we_out_d;
            dest_out_q   <= dest_out_d;
            rdata_buf_q  <= rdata_buf_d;
            first_q      <= first_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result_out = result_out_q;
    assign PC_out     = pc_out_q;
    assign gr_we_out  = gr_we_out_q;
    assign dest_out   = dest_out_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and write-back. It accepts the registered execute bundle over a valid/ready handshake and captures the synchronous data-SRAM read word. For divide instructions it collects the divider response. It then produces the final write-back value, registered toward WB.

## Interface
Parameters:
- `RESET_PC`, default `32'h1c000000`: reset value of `PC_out`.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  execute bundle valid.
- `in_ready`  out  1  stage can accept the bundle this cycle.
- `out_valid`  out  1  registered WB bundle valid.
- `out_ready`  in  1  WB can accept.
- `PC`  in  32  instruction PC.
- `ex_result`  in  32  ALU/MUL result; also the load address.
- `load_op`  in  8  one-hot: [0] ld.b, [1] ld.h, [2] ld.w, [3] ld.bu, [4] ld.hu; [7:5] reserved, zero.
- `div_op`  in  4  one-hot: [0] div.w, [1] mod.w, [2] div.wu, [3] mod.wu.
- `res_from_mem`  in  1  write-back value is load data.
- `res_from_div`  in  1  write-back value comes from the divider.
- `gr_we`  in  1  register-file write enable.
- `dest`  in  5  destination register.
- `data_sram_rdata`  in  32  read word, valid only in the first cycle an instruction occupies MEM.
- `from_div_resp_valid`  in  1  divider response valid.
- `to_div_resp_ready`  out  1  stage consumes the divider response.
- `div_quotient`  in  32  divider quotient.
- `div_remainder`  in  32  divider remainder.
- `result`  out  32  combinational final value for the current MEM instruction (bypass).
- `result_out`  out  32  registered final value.
- `PC_out`  out  32  registered PC.
- `gr_we_out`  out  1  registered write enable.
- `dest_out`  out  5  registered destination.

## Operation
- The input bundle is held by the upstream stage and stays stable while `in_valid` is high and the stage has not yet accepted it.
- `first` flag:
  - set to 1 on the cycle after a handshake (`in_valid & in_ready`) in which the stage was empty or advancing;
  - cleared on the next cycle while the instruction is still held.
- `rdata_buf` captures `data_sram_rdata` when `first` is 1.
- Effective word: `rword = first ? data_sram_rdata : rdata_buf`.
- Load extract, with byte offset `ex_result[1:0]`:
  - ld.b / ld.bu select `rword[8*off +: 8]`, then sign- or zero-extend;
  - ld.h / ld.hu select `rword[16*off[1] +: 16]`, then sign- or zero-extend;
  - ld.w passes `rword`.
- Divider:
  - `to_div_resp_ready = in_valid & res_from_div & out_ready`;
  - the response is consumed only when forwarded to WB that same cycle, so no hold register is needed;
  - div.w and div.wu select `div_quotient`; mod.w and mod.wu select `div_remainder`.
- `result` source select: load data if `res_from_mem`, else divider value if `res_from_div`, else `ex_result`.
- `ready_go = !in_valid | !res_from_div | from_div_resp_valid`.
- `in_ready = ~rst & (~in_valid | ready_go & out_ready)`.
- `out_valid`:
  - reset to 0;
  - otherwise, when `out_ready` is high, loads `in_valid & ready_go`;
  - otherwise holds.
- Data registers update only on `in_valid & ready_go & out_ready`.
- Reset values: `result_out` 0, `PC_out` `RESET_PC`, `gr_we_out` 0, `dest_out` 0, `rdata_buf` 0, `first` 0.

## Timing
- Latency: one cycle from handshake to `out_valid` when neither a divider wait nor a WB stall occurs.
- Divide instruction: stalls until `from_div_resp_valid`. The response, the handshake and the WB register load all occur in the same cycle.
- WB stall during a load: `rdata_buf` preserves the word, and the value is unchanged after any number of stall cycles.
- Back-to-back loads: `first` re-asserts every cycle and each load uses its own `data_sram_rdata`.
- `out_ready` low with `out_valid` high: all outputs hold and `in_ready` is 0.
- Reset mid-divide: `to_div_resp_ready` drops with `rst`, and no response is consumed during reset.
- Invalid misaligned offsets are not checked; the extract uses the address bits as given.

## Structure
- Shared package (LoongArch pipeline constants):
  - `LOAD_OP_*` and `DIV_OP_*` one-hot bit indices;
  - `RESET_PC`.
- One natural sub-module, `load_extend`: combinational `rword`, `load_op`, offset → 32-bit value. Reusable by a future unaligned-exception checker.

## Test plan
- Sign-extended byte load: ld.b, `ex_result=…0x2`, `rdata=32'h12_80_34_56`, `out_ready=1` → next cycle `out_valid=1`, `result_out=32'hFFFFFF80`.
- Zero-extended halfword load across a WB stall: ld.hu, off 2, `rdata=32'hBEEF_0001`; the bus changes to garbage, and `out_ready` is 0 for 3 cycles after the instruction enters MEM → `result_out=32'h0000BEEF` on release.
- Divider wait: mod.w with `from_div_resp_valid` low for 5 cycles → `in_ready=0` and `to_div_resp_ready=1` throughout. The response arrives with `div_remainder=32'hFFFFFFFD` → handshake that cycle, then `result_out=32'hFFFFFFFD`.
- Back-to-back loads: ld.w, ld.w, with rdata `32'hA`, `32'hB` on consecutive cycles → WB sees `32'hA` then `32'hB` in consecutive cycles.
- Pass-through: non-mem, non-div instruction with `ex_result=32'h1234` and `dest=7` → `result_out=32'h1234`, `dest_out=7`; `result` bypass equals `32'h1234` combinationally.
- Reset mid-stall: assert `rst` during a divider wait → next cycle `out_valid=0`, `PC_out=32'h1c000000`, `to_div_resp_ready=0`.
